// File: rtl/maxpool_seq.sv
// ---------------------------------------------------------------------------
// maxpool_seq
//   Sequencer for the shared signed max comparator of the CNN max-pooling
//   stage. Folds each group of WINDOW consecutive signed activations into a
//   running maximum, one element per cycle. It emits one pooled result per
//   window. The OUTPUT state overlaps the take of a result with the first
//   accept of the next window, so continuous streams see no bubbles.
//
//   Optional feature macro: MAXPOOL_RELU_EN
//     defined   : fused ReLU on result capture (negative max -> 0)
//     undefined : out_data is the raw signed maximum
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort of partial window / pending result
//   in_valid   in   in_data is valid
//   in_ready   out  element accepted this cycle (combinational)
//   in_data    in   signed activation, DATA_BITS wide
//   out_valid  out  out_data holds a pooled result (registered)
//   out_ready  in   downstream accepts out_data
//   out_data   out  signed window maximum (registered)
//   busy       out  high while in ACCUM or OUTPUT
//   elem_cnt   out  elements accepted in the current window
// ---------------------------------------------------------------------------
module maxpool_seq #(
   parameter int DATA_BITS = 8,
   parameter int WINDOW    = 4,
   parameter int CNT_BITS  = $clog2(WINDOW) + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [DATA_BITS-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [DATA_BITS-1:0] out_data,
   output logic                        busy,
   output logic [CNT_BITS-1:0]         elem_cnt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCUM  = 2'd1;
   localparam logic [1:0] OUTPUT = 2'd2;

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_WIN = CNT_BITS'(WINDOW);

   // Result shaping applied once, when the window maximum is captured.
   function automatic logic signed [DATA_BITS-1:0] capture(
      input logic signed [DATA_BITS-1:0] v
   );
`ifdef MAXPOOL_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   logic [1:0]                  state_q, state_d;
   logic signed [DATA_BITS-1:0] acc_q, acc_d;
   logic [CNT_BITS-1:0]         cnt_q, cnt_d;
   logic                        vld_p1, vld_d;
   logic signed [DATA_BITS-1:0] res_p1, res_d;

   logic                        accept;
   logic                        take;
   logic signed [DATA_BITS-1:0] fold;
   logic [CNT_BITS-1:0]         cnt_inc;

   // clear masks in_ready so the element offered alongside it is not consumed.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE, ACCUM: in_ready = 1'b1;
         OUTPUT:      in_ready = out_ready;
         default:     in_ready = 1'b0;
      endcase
      if (clear) in_ready = 1'b0;
   end

   assign accept  = in_valid & in_ready;
   assign take    = vld_p1 & out_ready;
   // Strict greater-than: on ties the existing maximum is kept.
   assign fold    = (in_data > acc_q) ? in_data : acc_q;
   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      vld_d   = vld_p1;
      res_d   = res_p1;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_d = in_data;
                  cnt_d = CNT_ONE;
                  if (WINDOW == 1) begin
                     state_d = OUTPUT;
                     vld_d   = 1'b1;
                     res_d   = capture(in_data);
                  end else begin
                     state_d = ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_d = fold;
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_WIN) begin
                     state_d = OUTPUT;
                     vld_d   = 1'b1;
                     res_d   = capture(fold);
                  end
               end
            end
            OUTPUT: begin
               // accept implies take here, since in_ready follows out_ready.
               if (take && accept) begin
                  acc_d = in_data;
                  cnt_d = CNT_ONE;
                  if (WINDOW == 1) begin
                     state_d = OUTPUT;
                     vld_d   = 1'b1;
                     res_d   = capture(in_data);
                  end else begin
                     state_d = ACCUM;
                     vld_d   = 1'b0;
                  end
               end else if (take) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  vld_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               vld_d   = 1'b0;
            end
         endcase
      end
   end

   // ---- stage p1: state, fold accumulator and registered result ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         vld_p1  <= 1'b0;
         res_p1  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         vld_p1  <= vld_d;
         res_p1  <= res_d;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = res_p1;
   assign busy      = (state_q != IDLE);
   assign elem_cnt  = cnt_q;

endmodule

// File: tb/tb_maxpool_seq.sv
module tb_maxpool_seq;

   localparam int DW  = 8;
   localparam int WIN = 4;
   localparam int CB  = $clog2(WIN) + 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 clear = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [DW-1:0] out_data;
   logic                 busy;
   logic [CB-1:0]        elem_cnt;

   int total = 0;
   int bad   = 0;
   logic signed [DW-1:0] sb[$];
   logic signed [DW-1:0] mon_exp;

   always #5 clk = ~clk;

   maxpool_seq #(.DATA_BITS(DW), .WINDOW(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .elem_cnt(elem_cnt)
   );

   function automatic logic signed [DW-1:0] model(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Scoreboard: every result taken by downstream is matched against the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got=%0d required=none", out_data);
         end else begin
            mon_exp = sb.pop_front();
            if (out_data !== mon_exp) begin
               bad++;
               $display("FAIL sb_result got=%0d required=%0d", out_data, mon_exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic signed [DW-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
      total++; if (out_data !== 8'sd0) begin bad++; $display("FAIL rst_out_data got=%0d required=0", out_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
      total++; if (elem_cnt !== 3'd0) begin bad++; $display("FAIL rst_elem_cnt got=%0d required=0", elem_cnt); end
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      feed(8'sd3);
      total++; if (elem_cnt !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL basic_first cnt=%0d busy=%b required=1,1", elem_cnt, busy); end
      feed(-8'sd5);
      feed(8'sd7);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early out_valid=%b required=0", out_valid); end
      sb.push_back(model(8'sd7));
      feed(8'sd2);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency out_valid=%b required=1", out_valid); end
      total++; if (elem_cnt !== 3'd4) begin bad++; $display("FAIL basic_cnt got=%0d required=4", elem_cnt); end
      step();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle out_valid=%b busy=%b required=0,0", out_valid, busy); end
   endtask

   task automatic test_signed();
      logic signed [DW-1:0] w1 [4];
      logic signed [DW-1:0] w2 [4];
      w1 = '{-8'sd8, -8'sd3, -8'sd100, -8'sd3};
      w2 = '{-8'sd128, 8'sd127, 8'sd0, 8'sd1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sb.push_back(model(-8'sd3));
         feed(w1[i]);
      end
      total++; if (out_data !== model(-8'sd3)) begin bad++; $display("FAIL neg_max got=%0d required=%0d", out_data, model(-8'sd3)); end
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sb.push_back(model(8'sd127));
         feed(w2[i]);
      end
      in_valid = 1'b0;
      total++; if (out_data !== 8'sd127) begin bad++; $display("FAIL extreme_max got=%0d required=127", out_data); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      feed(8'sd10);
      feed(8'sd20);
      feed(8'sd5);
      sb.push_back(model(8'sd20));
      feed(8'sd15);
      in_valid = 1'b1;
      in_data  = 8'sd9;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 8'sd20 || in_ready !== 1'b0 || elem_cnt !== 3'd4) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d vld=%b data=%0d rdy=%b cnt=%0d required=1,20,0,4", i, out_valid, out_data, in_ready, elem_cnt);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%b required=1", in_ready); end
      step();
      total++; if (elem_cnt !== 3'd1 || out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_overlap cnt=%0d vld=%b busy=%b required=1,0,1", elem_cnt, out_valid, busy); end
      feed(8'sd3);
      feed(8'sd2);
      sb.push_back(model(8'sd9));
      feed(8'sd1);
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b required=1", k, in_ready); end
         if (k % 4 == 0) sb.push_back(model(DW'(k)));
         feed(DW'(k));
         total++;
         if (out_valid !== (k % 4 == 0)) begin
            bad++;
            $display("FAIL b2b_valid k=%0d got=%b required=%b", k, out_valid, (k % 4 == 0));
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      feed(8'sd50);
      feed(8'sd60);
      clear    = 1'b1;
      in_data  = 8'sd99;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b required=0", in_ready); end
      step();
      clear = 1'b0;
      total++; if (elem_cnt !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL clr_cnt cnt=%0d busy=%b required=0,0", elem_cnt, busy); end
      feed(8'sd1);
      feed(8'sd2);
      feed(8'sd3);
      sb.push_back(model(8'sd4));
      feed(8'sd4);
      in_valid = 1'b0;
      step();
      // abort a pending result
      out_ready = 1'b0;
      feed(8'sd5);
      feed(8'sd6);
      feed(8'sd7);
      feed(8'sd8);
      in_valid = 1'b0;
      clear    = 1'b1;
      step();
      clear = 1'b0;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clr_output vld=%b busy=%b required=0,0", out_valid, busy); end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      feed(8'sd10);
      feed(8'sd11);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || elem_cnt !== 3'd0) begin bad++; $display("FAIL arst_mid busy=%b cnt=%0d required=0,0", busy, elem_cnt); end
      step();
      rst_n = 1'b1;
      out_ready = 1'b0;
      feed(8'sd1);
      feed(8'sd2);
      feed(8'sd3);
      feed(8'sd4);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_data !== 8'sd0 || busy !== 1'b0) begin bad++; $display("FAIL arst_out vld=%b data=%0d busy=%b required=0,0,0", out_valid, out_data, busy); end
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      feed(-8'sd1);
      feed(-8'sd2);
      feed(-8'sd3);
      sb.push_back(model(-8'sd1));
      feed(-8'sd4);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_recover vld=%b required=1", out_valid); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_async_reset();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
